// File: rtl/smc_pkg.sv
// rtl/smc_pkg.sv - shared constants, FSM state type and width helper for smc_stream
package smc_pkg;

  localparam int MODE_METRIC_BIT = 0;
  localparam int MODE_TOP_BIT    = 1;

  localparam int W_A = 3;
  localparam int W_B = 4;
  localparam int W_C = 5;

  localparam int DIV_WTD   = 12;
  localparam int DIV_PLAIN = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_OUT
  } state_e;

  function automatic int dw_of(input int vw);
    return 3 * vw - 1;
  endfunction

endpackage

// File: rtl/smc_stream_if.sv
// rtl/smc_stream_if.sv - beat input and result output bundle for smc_stream
interface smc_stream_if #(
  parameter int VW = 3
) ();
  localparam int DW = smc_pkg::dw_of(VW);

  logic          in_valid;
  logic          in_ready;
  logic [1:0]    mode;
  logic [VW-1:0] W;
  logic [VW-1:0] V_GS;
  logic [VW-1:0] V_DS;
  logic          out_valid;
  logic [DW-1:0] out_n;

  modport slave (
    input  in_valid, mode, W, V_GS, V_DS,
    output in_ready, out_valid, out_n
  );

  modport master (
    output in_valid, mode, W, V_GS, V_DS,
    input  in_ready, out_valid, out_n
  );
endinterface

// File: rtl/smc_iv_calc.sv
// rtl/smc_iv_calc.sv - combinational drain current and transconductance of one device
module smc_iv_calc
  import smc_pkg::*;
#(
  parameter int VW = 3
) (
  input  logic [VW-1:0]        w_i,
  input  logic [VW-1:0]        v_gs_i,
  input  logic [VW-1:0]        v_ds_i,
  output logic [dw_of(VW)-1:0] id_o,
  output logic [dw_of(VW)-1:0] gm_o
);
  localparam int DW = dw_of(VW);
  localparam int PW = 3 * VW;

  logic [VW-1:0] v1;
  logic [PW-1:0] v1e, vdse, we, idb, gmb;

  always_comb begin
    // V_GS=0 is cutoff: clamp instead of wrapping to a large overdrive
    v1   = (v_gs_i == '0) ? '0 : v_gs_i - VW'(1);
    v1e  = PW'(v1);
    vdse = PW'(v_ds_i);
    we   = PW'(w_i);
    if (v1 > v_ds_i) begin
      idb = vdse * ((v1e << 1) - vdse);
      gmb = vdse << 1;
    end else begin
      idb = v1e * v1e;
      gmb = v1e << 1;
    end
    id_o = DW'((idb * we) / PW'(3));
    gm_o = DW'((gmb * we) / PW'(3));
  end

endmodule

// File: rtl/smc_stream.sv
// rtl/smc_stream.sv - serial SMC evaluator: sorted metric buffer, mean of top/bottom three
// Optional SMC_ROUND_EN selects round-half-up for the final mean instead of floor.
module smc_stream
  import smc_pkg::*;
#(
  parameter int N_DEV = 6,
  parameter int VW    = 3
) (
  input logic         clk,
  input logic         rst_n,
  smc_stream_if.slave s
);
  localparam int DW = dw_of(VW);
  localparam int AW = DW + 4;
  localparam int CW = $clog2(N_DEV + 1);
`ifdef SMC_ROUND_EN
  localparam int RND_W = DIV_WTD / 2;
  localparam int RND_P = DIV_PLAIN / 2;
`else
  localparam int RND_W = 0;
  localparam int RND_P = 0;
`endif

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      mode_q, mode_d;
  logic [DW-1:0]   out_q, out_d;
  logic [DW-1:0]   buf_q [N_DEV];
  logic [DW-1:0]   buf_d [N_DEV];
  logic [DW-1:0]   ins   [N_DEV];
  logic [N_DEV-1:0] ge;
  logic [DW-1:0]   id, gm, metric, mean, a, b, c;
  logic [AW-1:0]   sum;
  logic            use_id, accept;

  smc_iv_calc #(.VW(VW)) u_iv (
    .w_i   (s.W),
    .v_gs_i(s.V_GS),
    .v_ds_i(s.V_DS),
    .id_o  (id),
    .gm_o  (gm)
  );

  assign s.in_ready  = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign s.out_valid = (state_q == S_OUT);
  assign s.out_n     = out_q;
  assign accept      = s.in_valid && s.in_ready;
  // the first beat's mode is not registered yet, so take it straight from the port
  assign use_id = (state_q == S_IDLE) ? s.mode[MODE_METRIC_BIT] : mode_q[MODE_METRIC_BIT];
  assign metric = use_id ? id : gm;

  // ge marks occupied slots that stay ahead of the new value (equal entries keep priority)
  always_comb begin
    for (int i = 0; i < N_DEV; i++) begin
      ge[i] = (CW'(i) < cnt_q) && (buf_q[i] >= metric);
    end
    ins[0] = ge[0] ? buf_q[0] : metric;
    for (int i = 1; i < N_DEV; i++) begin
      ins[i] = ge[i] ? buf_q[i] : (ge[i-1] ? metric : buf_q[i-1]);
    end
  end

  always_comb begin
    if (mode_q[MODE_TOP_BIT]) begin
      a = buf_q[0];
      b = buf_q[1];
      c = buf_q[2];
    end else begin
      a = buf_q[N_DEV-3];
      b = buf_q[N_DEV-2];
      c = buf_q[N_DEV-1];
    end
    if (mode_q[MODE_METRIC_BIT]) begin
      sum  = AW'(W_A) * AW'(a) + AW'(W_B) * AW'(b) + AW'(W_C) * AW'(c) + AW'(RND_W);
      mean = DW'(sum / AW'(DIV_WTD));
    end else begin
      sum  = AW'(a) + AW'(b) + AW'(c) + AW'(RND_P);
      mean = DW'(sum / AW'(DIV_PLAIN));
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    out_d   = '0;
    buf_d   = buf_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          mode_d  = s.mode;
          buf_d   = ins;
          cnt_d   = CW'(1);
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          buf_d = ins;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(N_DEV - 1)) state_d = S_CALC;
        end
      end
      S_CALC: begin
        out_d   = mean;
        state_d = S_OUT;
      end
      S_OUT: begin
        cnt_d   = '0;
        for (int i = 0; i < N_DEV; i++) buf_d[i] = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
      out_q   <= '0;
      for (int i = 0; i < N_DEV; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      out_q   <= out_d;
      for (int i = 0; i < N_DEV; i++) buf_q[i] <= buf_d[i];
    end
  end

endmodule

// File: tb/tb_smc_stream.sv
// tb/tb_smc_stream.sv - directed and randomized self-checking bench for smc_stream
module tb_smc_stream;
  localparam int N_DEV = 6;
  localparam int VW    = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  smc_stream_if #(.VW(VW)) bus ();

  smc_stream #(.N_DEV(N_DEV), .VW(VW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .s    (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  int         fw [N_DEV];
  int         fg [N_DEV];
  int         fd [N_DEV];
  logic [1:0] fm [N_DEV];
  int         gap_max = 0;

`ifdef SMC_ROUND_EN
  localparam int EXP_ID_BOT = 20;
`else
  localparam int EXP_ID_BOT = 19;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_metric(input int w, input int vgs, input int vds, input bit use_id);
    int v1, idb, gmb;
    v1 = (vgs == 0) ? 0 : vgs - 1;
    if (v1 > vds) begin
      idb = vds * (2 * v1 - vds);
      gmb = 2 * vds;
    end else begin
      idb = v1 * v1;
      gmb = 2 * v1;
    end
    return use_id ? (idb * w) / 3 : (gmb * w) / 3;
  endfunction

  function automatic int model_mean();
    int q[$];
    int a, b, c, sum, div;
    for (int i = 0; i < N_DEV; i++) q.push_back(model_metric(fw[i], fg[i], fd[i], fm[0][0]));
    q.rsort();
    if (fm[0][1]) begin
      a = q[0]; b = q[1]; c = q[2];
    end else begin
      a = q[N_DEV-3]; b = q[N_DEV-2]; c = q[N_DEV-1];
    end
    if (fm[0][0]) begin
      sum = 3 * a + 4 * b + 5 * c; div = 12;
    end else begin
      sum = a + b + c; div = 3;
    end
`ifdef SMC_ROUND_EN
    sum = sum + div / 2;
`endif
    return sum / div;
  endfunction

  task automatic drive_idle();
    bus.in_valid = 1'b0;
    bus.mode     = 2'($urandom);
    bus.W        = VW'($urandom);
    bus.V_GS     = VW'($urandom);
    bus.V_DS     = VW'($urandom);
  endtask

  task automatic set_uniform(input int w, input int g, input int d, input logic [1:0] m);
    for (int i = 0; i < N_DEV; i++) begin
      fw[i] = w; fg[i] = g; fd[i] = d; fm[i] = m;
    end
  endtask

  task automatic set_shared(input logic [1:0] m);
    for (int i = 0; i < N_DEV; i++) begin
      fw[i] = 7; fg[i] = 7; fd[i] = i; fm[i] = m;
    end
  endtask

  task automatic send_beats(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      int g;
      g = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
      repeat (g) begin
        drive_idle();
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.mode     = fm[i];
      bus.W        = VW'(fw[i]);
      bus.V_GS     = VW'(fg[i]);
      bus.V_DS     = VW'(fd[i]);
      check({tag, "_rdy_load"}, 32'(bus.in_ready), 32'd1);
      check({tag, "_ov_load"}, 32'(bus.out_valid), 32'd0);
      @(posedge clk); #1;
    end
    drive_idle();
  endtask

  // in_valid stays high through CALC/OUT to prove it is ignored while not ready
  task automatic run_frame(input string tag, input int exp);
    send_beats(tag, N_DEV);
    bus.in_valid = 1'b1;
    check({tag, "_rdy_calc"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_ov_calc"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, "_ov_out"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_out_n"}, 32'(bus.out_n), 32'(exp));
    check({tag, "_rdy_out"}, 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check({tag, "_ov_after"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_n_zero"}, 32'(bus.out_n), 32'd0);
    check({tag, "_rdy_after"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_rdy", 32'(bus.in_ready), 32'd1);
    check("reset_ov", 32'(bus.out_valid), 32'd0);
    check("reset_out_n", 32'(bus.out_n), 32'd0);

    set_uniform(3, 3, 7, 2'b11);
    run_frame("t1_uniform_11", 4);
    set_uniform(3, 3, 7, 2'b00);
    run_frame("t1_uniform_00", 4);

    set_shared(2'b11);
    run_frame("t2_id_top", 71);
    set_shared(2'b10);
    run_frame("t2_gm_top", 18);
    set_shared(2'b00);
    run_frame("t3_gm_bot", 4);
    set_shared(2'b01);
    run_frame("t3_id_bot", EXP_ID_BOT);

    set_shared(2'b11);
    for (int i = 1; i < N_DEV; i++) fm[i] = 2'($urandom_range(2, 0));
    run_frame("t4_mode_toggle", 71);
    gap_max = 3;
    set_shared(2'b10);
    run_frame("t4_gaps", 18);
    gap_max = 0;

    set_shared(2'b00);
    fw[0] = 7; fg[0] = 0; fd[0] = 3;
    run_frame("t5_cutoff", 4);

    set_shared(2'b11);
    send_beats("t5_abort", 3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("t5_abort_rdy", 32'(bus.in_ready), 32'd1);
    check("t5_abort_out_n", 32'(bus.out_n), 32'd0);
    for (int i = 0; i < N_DEV + 3; i++) begin
      check("t5_abort_ov", 32'(bus.out_valid), 32'd0);
      @(posedge clk); #1;
    end
    set_shared(2'b11);
    run_frame("t5_fresh", 71);

    gap_max = 2;
    for (int f = 0; f < 24; f++) begin
      for (int i = 0; i < N_DEV; i++) begin
        fw[i] = $urandom_range(7, 0);
        fg[i] = $urandom_range(7, 0);
        fd[i] = $urandom_range(7, 0);
        fm[i] = 2'($urandom);
      end
      run_frame("rand", model_mean());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
